// File: rtl/coherent_average_mc_if.sv
// coherent_average_mc_if: averaged-sample output stream.
// Master drives data/valid/last; slave drives ready.
interface coherent_average_mc_if #(
  parameter int W = 28
) ();
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/coherent_average_mc.sv
// coherent_average_mc: multi-channel coherent averager over 2^m periods.
// Define COH_AVG_ROUND_EN for round-half-up instead of truncation.
module coherent_average_mc #(
  parameter int DATA_W     = 14,
  parameter int N_SAMPLES  = 128,
  parameter int LOG2_M_MAX = 13,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [$clog2(LOG2_M_MAX+1)-1:0] m_log2,
  input  logic [CHANNELS*DATA_W-1:0]     data_in,
  input  logic                           data_valid,
  input  logic                           sync,
  coherent_average_mc_if.master          m_out,
  output logic                           busy,
  output logic                           done,
  output logic                           sync_err,
  output logic                           overrun
);
  localparam int ACC_W = DATA_W + LOG2_M_MAX;
  localparam int M_W   = $clog2(LOG2_M_MAX+1);
  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam int CNT_W = $clog2(N_SAMPLES+1);
  localparam int FR_W  = LOG2_M_MAX + 1;
  localparam int AW    = CHANNELS * ACC_W;
  localparam int OW    = CHANNELS * DATA_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES-1);

  typedef enum logic [1:0] {IDLE, ARM, ACCUM, DUMP} state_t;

  state_t           state_q, state_d;
  logic [M_W-1:0]   m_q, m_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FR_W-1:0]  frame_q, frame_d;
  logic             stop_q, stop_d;
  logic             sync_err_q, sync_err_d;
  logic             overrun_q, overrun_d;
  logic             done_q, done_d;

  logic             p1_valid_q, p1_valid_d;
  logic             p1_first_q, p1_first_d;
  logic [IDX_W-1:0] p1_idx_q, p1_idx_d;
  logic [OW-1:0]    p1_data_q, p1_data_d;

  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             rdv_q, rdv_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [OW-1:0]    out_data_q, out_data_d;

  logic [AW-1:0]    acc_ram [N_SAMPLES];
  logic [AW-1:0]    acc_rd_q;
  logic             rd_en;
  logic             wr_en;
  logic [IDX_W-1:0] rd_addr;
  logic [AW-1:0]    wr_data;
  logic [ACC_W-1:0] sx;

  logic             accept;
  logic             frame_end;
  logic             fire;
  logic             rd_move;
  logic             issue;
  logic [FR_W-1:0]  frame_mask;
  logic signed [ACC_W-1:0] bias;
  logic [OW-1:0]    avg;

  always_comb begin
    frame_mask = (FR_W'(1) << m_q) - FR_W'(1);
    frame_end  = (idx_q == IDX_LAST) && (frame_q == frame_mask);
    accept     = enable && data_valid &&
                 ((state_q == ARM && sync) || state_q == ACCUM);
    fire       = out_valid_q && m_out.out_ready;
    rd_move    = rdv_q && (!out_valid_q || fire);
    issue      = (state_q == DUMP) &&
                 (rd_cnt_q < CNT_W'(N_SAMPLES)) &&
                 (!rdv_q || rd_move);
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    stop_d     = stop_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    done_d     = 1'b0;
    sync_err_d = sync_err_q;
    overrun_d  = overrun_q;
    unique case (state_q)
      IDLE: begin
        idx_d   = '0;
        frame_d = '0;
        stop_d  = 1'b0;
        m_d     = (m_log2 > M_W'(LOG2_M_MAX)) ?
                  M_W'(LOG2_M_MAX) : m_log2;
        if (enable) state_d = ARM;
      end
      ARM: begin
        idx_d   = '0;
        frame_d = '0;
        stop_d  = 1'b0;
        if (!enable) begin
          state_d = IDLE;
        end else if (accept) begin
          state_d = ACCUM;
          idx_d   = IDX_W'(1);
        end
      end
      ACCUM: begin
        // Phase is owned by idx; a stray sync only raises the flag.
        if (data_valid && sync && idx_q != '0) sync_err_d = 1'b1;
        if (!enable) begin
          state_d = IDLE;
        end else if (accept) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            frame_d = frame_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
          if (frame_end) state_d = DUMP;
        end
      end
      DUMP: begin
        if (data_valid) overrun_d = 1'b1;
        if (!enable) stop_d = 1'b1;
        if (fire && out_last_q) begin
          done_d  = 1'b1;
          state_d = (enable && !stop_q) ? ARM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read at accept, write one cycle later; consecutive samples
  // never share an address, so no forwarding is needed.
  always_comb begin
    p1_valid_d = accept;
    p1_first_d = (state_q == ARM) || (frame_q == '0);
    p1_idx_d   = idx_q;
    p1_data_d  = data_in;
    wr_en      = p1_valid_q;
    rd_en      = accept || issue;
    rd_addr    = accept ? idx_q : rd_cnt_q[IDX_W-1:0];
    wr_data    = '0;
    sx         = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sx = {{LOG2_M_MAX{p1_data_q[c*DATA_W+DATA_W-1]}},
            p1_data_q[c*DATA_W +: DATA_W]};
      wr_data[c*ACC_W +: ACC_W] = p1_first_q ? sx :
        acc_rd_q[c*ACC_W +: ACC_W] + sx;
    end
  end

  always_comb begin
    bias = '0;
`ifdef COH_AVG_ROUND_EN
    if (m_q != '0) bias = ACC_W'(1) << (m_q - 1'b1);
`endif
    avg = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      avg[c*DATA_W +: DATA_W] = DATA_W'(
        (signed'(acc_rd_q[c*ACC_W +: ACC_W]) + bias) >>> m_q);
    end
  end

  // Read register feeds the output slot; a new read is issued only
  // when the read register is free or moving on this cycle.
  always_comb begin
    rd_cnt_d    = (state_q == DUMP) ?
                  rd_cnt_q + CNT_W'(issue) : '0;
    rdv_d       = issue ? 1'b1 : (rd_move ? 1'b0 : rdv_q);
    rd_idx_d    = issue ? rd_cnt_q[IDX_W-1:0] : rd_idx_q;
    out_valid_d = rd_move ? 1'b1 : (fire ? 1'b0 : out_valid_q);
    out_data_d  = rd_move ? avg : out_data_q;
    out_last_d  = rd_move ? (rd_idx_q == IDX_LAST) : out_last_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) acc_ram[p1_idx_q] <= wr_data;
    if (rd_en) acc_rd_q <= acc_ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      m_q         <= '0;
      idx_q       <= '0;
      frame_q     <= '0;
      stop_q      <= 1'b0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_first_q  <= 1'b0;
      p1_idx_q    <= '0;
      p1_data_q   <= '0;
      rd_cnt_q    <= '0;
      rdv_q       <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      stop_q      <= stop_d;
      sync_err_q  <= sync_err_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      p1_valid_q  <= p1_valid_d;
      p1_first_q  <= p1_first_d;
      p1_idx_q    <= p1_idx_d;
      p1_data_q   <= p1_data_d;
      rd_cnt_q    <= rd_cnt_d;
      rdv_q       <= rdv_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign m_out.out_data  = out_data_q;
  assign m_out.out_valid = out_valid_q;
  assign m_out.out_last  = out_last_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign sync_err        = sync_err_q;
  assign overrun         = overrun_q;
endmodule

// File: tb/tb_coherent_average_mc.sv
// tb_coherent_average_mc: scoreboard bench, N=8 instance plus an N=2
// instance for the full-scale m=13 case.
module tb_coherent_average_mc;
  localparam int DW = 14;
  localparam int MW = 4;

  typedef struct packed {
    logic [27:0] d;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          enable_a = 0, dv_a = 0, sync_a = 0;
  logic [MW-1:0] m_a = '0;
  logic [27:0]   din_a = '0;
  logic          busy_a, done_a, serr_a, ovr_a;

  logic          enable_b = 0, dv_b = 0, sync_b = 0;
  logic [MW-1:0] m_b = '0;
  logic [27:0]   din_b = '0;
  logic          busy_b, done_b, serr_b, ovr_b;

  coherent_average_mc_if #(.W(28)) oa ();
  coherent_average_mc_if #(.W(28)) ob ();

  coherent_average_mc #(
    .DATA_W(DW), .N_SAMPLES(8), .LOG2_M_MAX(13), .CHANNELS(2)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable_a), .m_log2(m_a),
    .data_in(din_a), .data_valid(dv_a), .sync(sync_a),
    .m_out(oa), .busy(busy_a), .done(done_a),
    .sync_err(serr_a), .overrun(ovr_a)
  );

  coherent_average_mc #(
    .DATA_W(DW), .N_SAMPLES(2), .LOG2_M_MAX(13), .CHANNELS(2)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .m_log2(m_b),
    .data_in(din_b), .data_valid(dv_b), .sync(sync_b),
    .m_out(ob), .busy(busy_b), .done(done_b),
    .sync_err(serr_b), .overrun(ovr_b)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] pk(input int c0, input int c1);
    logic [13:0] a, b;
    a = 14'(c0);
    b = 14'(c1);
    return {b, a};
  endfunction

  task automatic push_a(input int c0, input int c1, input logic l);
    exp_t e;
    e.d = pk(c0, c1);
    e.l = l;
    qa.push_back(e);
  endtask

  task automatic send_a(input int c0, input int c1, input logic s);
    din_a  = pk(c0, c1);
    sync_a = s;
    dv_a   = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic restart_a(input logic [MW-1:0] m);
    enable_a = 1'b0;
    @(posedge clk); #1;
    m_a      = m;
    enable_a = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_done_a(input string nm, input bit rnd);
    bit seen;
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      if (rnd) oa.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done_a) seen = 1;
    end
    oa.out_ready = 1'b1;
    chk(nm, 64'(seen), 1);
  endtask

  initial begin : mon_a
    logic [27:0] hd;
    logic        hl;
    bit          st;
    exp_t        e;
    st = 0;
    forever begin
      @(negedge clk);
      if (reset || !oa.out_valid) begin
        st = 0;
      end else begin
        if (st) chk("stable_a", {hl, hd}, {oa.out_last, oa.out_data});
        if (oa.out_ready) begin
          st = 0;
          if (qa.size() == 0) begin
            chk("extra_a", 64'(oa.out_valid), 0);
          end else begin
            e = qa.pop_front();
            chk("data_a", oa.out_data, e.d);
            chk("last_a", 64'(oa.out_last), 64'(e.l));
          end
        end else begin
          st = 1;
          hd = oa.out_data;
          hl = oa.out_last;
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && ob.out_valid && ob.out_ready) begin
        if (qb.size() == 0) begin
          chk("extra_b", 64'(ob.out_valid), 0);
        end else begin
          e = qb.pop_front();
          chk("data_b", ob.out_data, e.d);
          chk("last_b", 64'(ob.out_last), 64'(e.l));
        end
      end
    end
  end

  initial begin : stim
    bit   seen;
    exp_t e;
    int   r0, r1;
    oa.out_ready = 1'b1;
    ob.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_busy", 64'(busy_a), 0);
    chk("rst_done", 64'(done_a), 0);
    chk("rst_serr", 64'(serr_a), 0);
    chk("rst_ovr", 64'(ovr_a), 0);
    chk("rst_valid", 64'(oa.out_valid), 0);
    chk("rst_last", 64'(oa.out_last), 0);
    chk("rst_data", oa.out_data, 0);

    // ramp: ch0=idx, ch1=-idx over 4 periods
    for (int i = 0; i < 8; i++) push_a(i, -i, i == 7);
    restart_a(2);
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 8; i++) send_a(i, -i, i == 0);
    dv_a = 1'b0;
    @(posedge clk); #1;
    chk("lat_early", 64'(oa.out_valid), 0);
    @(posedge clk); #1;
    chk("lat_on", 64'(oa.out_valid), 1);
    wait_done_a("done_t1", 0);
    chk("t1_busy_arm", 64'(busy_a), 1);
    chk("t1_serr", 64'(serr_a), 0);

    // 3+4 and -3-4 over two periods
`ifdef COH_AVG_ROUND_EN
    r0 = 4; r1 = -3;
`else
    r0 = 3; r1 = -4;
`endif
    for (int i = 0; i < 8; i++) push_a(r0, r1, i == 7);
    restart_a(1);
    for (int i = 0; i < 8; i++) send_a(3, -3, i == 0);
    for (int i = 0; i < 8; i++) send_a(4, -4, 1'b0);
    dv_a = 1'b0;
    wait_done_a("done_t2", 0);
    chk("t2_ovr", 64'(ovr_a), 0);

    // m=0, random backpressure, one sample injected during dump
    for (int i = 0; i < 8; i++) push_a(10*i + 1, -100 + 3*i, i == 7);
    restart_a(0);
    for (int i = 0; i < 8; i++) send_a(10*i + 1, -100 + 3*i, i == 0);
    sync_a = 1'b0;
    @(posedge clk); #1;
    dv_a = 1'b0;
    wait_done_a("done_t4", 1);
    chk("t4_ovr", 64'(ovr_a), 1);
    chk("t4_serr", 64'(serr_a), 0);

    // stray sync at idx 3
    for (int i = 0; i < 8; i++) push_a(2*i + 1, -5, i == 7);
    restart_a(1);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++)
        send_a(2*i + 1, -5, (i == 0) || (f == 0 && i == 3));
    dv_a = 1'b0;
    wait_done_a("done_t5", 0);
    chk("t5_serr", 64'(serr_a), 1);

    // abort mid-accumulation
    for (int i = 0; i < 4; i++) send_a(i, i, i == 0);
    enable_a = 1'b0;
    send_a(9, 9, 1'b0);
    chk("abort_busy", 64'(busy_a), 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      send_a(9, 9, 1'b0);
      if (oa.out_valid || done_a) seen = 1;
    end
    dv_a = 1'b0;
    chk("abort_quiet", 64'(seen), 0);

    // full-scale m=13 on N=2, then m=15 clamped to 13
    for (int run = 0; run < 2; run++) begin
      r0 = (run == 0) ? -8192 : 8191;
      for (int i = 0; i < 2; i++) begin
        e.d = pk(r0, r0);
        e.l = (i == 1);
        qb.push_back(e);
      end
      enable_b = 1'b0;
      @(posedge clk); #1;
      m_b      = (run == 0) ? 4'd13 : 4'd15;
      enable_b = 1'b1;
      @(posedge clk); #1;
      din_b = pk(r0, r0);
      dv_b  = 1'b1;
      for (int f = 0; f < 8192; f++)
        for (int i = 0; i < 2; i++) begin
          sync_b = (i == 0);
          @(posedge clk); #1;
        end
      dv_b = 1'b0;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(posedge clk); #1;
        if (done_b) seen = 1;
      end
      chk("done_b", 64'(seen), 1);
    end
    enable_b = 1'b0;

    // reset while a dump is stalled
    oa.out_ready = 1'b0;
    restart_a(0);
    for (int i = 0; i < 8; i++) send_a(7, 7, i == 0);
    dv_a = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (oa.out_valid) seen = 1;
    end
    chk("t6_valid", 64'(seen), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_valid0", 64'(oa.out_valid), 0);
    chk("t6_busy", 64'(busy_a), 0);
    chk("t6_serr", 64'(serr_a), 0);
    chk("t6_ovr", 64'(ovr_a), 0);
    chk("t6_done", 64'(done_a), 0);
    reset    = 1'b0;
    enable_a = 1'b0;
    oa.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    chk("qa_empty", 64'(qa.size()), 0);
    chk("qb_empty", 64'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
